// File: rtl/ipsxe_fft_chk_pkg.sv
// ---------------------------------------------------------------------------
// ipsxe_fft_chk_pkg
// Shared types and width helpers for the FFT result checker.
//   chk_state_e      : checker FSM states (IDLE / RUN / DONE)
//   clog2()          : ceiling log2 for sizing counters
//   dataout_width()  : component width rounded up to a whole number of bytes
//   frame_sum_width(): accumulator width, wide enough for N full-scale re+im
// ---------------------------------------------------------------------------
package ipsxe_fft_chk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } chk_state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

   function automatic int dataout_width(input int ow);
      return ((ow + 7) / 8) * 8;
   endfunction

   // N samples of (re + im): one bit for the re+im add, LOG2 bits for N beats
   function automatic int frame_sum_width(input int ow, input int log2n);
      return ow + log2n + 1;
   endfunction

endpackage

// File: rtl/ipsxe_fft_chk_watchdog.sv
// ---------------------------------------------------------------------------
// ipsxe_fft_chk_watchdog
// Counts ticks since the last clear and flags expiry on the tick that makes
// the count reach LIMIT. The counter restarts after expiry.
//   i_aclk, i_areset : clock, asynchronous active-high reset
//   i_clr            : restart the count (wins over i_tick)
//   i_tick           : one idle cycle to count
//   o_expire         : high during the tick that reaches LIMIT
// ---------------------------------------------------------------------------
module ipsxe_fft_chk_watchdog
   import ipsxe_fft_chk_pkg::*;
#(
   parameter int LIMIT = 4095
) (
   input  logic i_aclk,
   input  logic i_areset,
   input  logic i_clr,
   input  logic i_tick,
   output logic o_expire
);

   localparam int CW = clog2(LIMIT + 1);

   logic [CW-1:0] r_cnt;

   // Combinational so the parent can register the timeout on this same edge
   assign o_expire = i_tick && !i_clr && (r_cnt == CW'(LIMIT - 1));

   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset)                r_cnt <= '0;
      else if (i_clr || o_expire)  r_cnt <= '0;
      else if (i_tick)             r_cnt <= r_cnt + 1'b1;
   end

endmodule

// File: rtl/ipsxe_fft_result_chk.sv
// ---------------------------------------------------------------------------
// ipsxe_fft_result_chk
// Checks the FFT core's AXI4-Stream output: per-beat index and tlast
// framing, per-frame signed sum of re+im, frame count, and a stall watchdog.
// Raises o_chk_finished after TEST_FRAME_NUM frames or on timeout.
// Ports:
//   i_aclk / i_areset / i_aclken : clock, async active-high reset, clock enable
//   i_start_test                 : (re)start pulse, highest priority
//   i_axi4s_data_*               : FFT output stream {im, re}, tuser = index
//   o_axi4s_data_tready          : ready (deterministic backpressure in RUN)
//   o_chk_finished / o_chk_pass  : test complete / no error seen
//   o_err_tlast/index/timeout    : sticky error flags
//   o_frm_cnt                    : frames completed (saturating)
//   o_frame_sum / _valid         : sum of last completed frame, update pulse
// ---------------------------------------------------------------------------
module ipsxe_fft_result_chk
   import ipsxe_fft_chk_pkg::*;
#(
   parameter int TEST_FRAME_NUM = 10,
   parameter int LOG2_FFT_LEN   = 4,
   parameter int OUTPUT_WIDTH   = 21,
   parameter int BP_EN          = 1,
   parameter int TIMEOUT_CYCLES = 4095
) (
   input  logic                                                 i_aclk,
   input  logic                                                 i_areset,
   input  logic                                                 i_aclken,
   input  logic                                                 i_start_test,
   input  logic                                                 i_axi4s_data_tvalid,
   input  logic [2*dataout_width(OUTPUT_WIDTH)-1:0]             i_axi4s_data_tdata,
   input  logic                                                 i_axi4s_data_tlast,
   input  logic [LOG2_FFT_LEN-1:0]                              i_axi4s_data_tuser,
   output logic                                                 o_axi4s_data_tready,
   output logic                                                 o_chk_finished,
   output logic                                                 o_chk_pass,
   output logic                                                 o_err_tlast,
   output logic                                                 o_err_index,
   output logic                                                 o_err_timeout,
   output logic [clog2(TEST_FRAME_NUM+1)-1:0]                   o_frm_cnt,
   output logic [frame_sum_width(OUTPUT_WIDTH,LOG2_FFT_LEN)-1:0] o_frame_sum,
   output logic                                                 o_frame_sum_valid
);

   localparam int DW  = dataout_width(OUTPUT_WIDTH);
   localparam int FW  = frame_sum_width(OUTPUT_WIDTH, LOG2_FFT_LEN);
   localparam int CW  = clog2(TEST_FRAME_NUM + 1);
   localparam int EXT = FW - OUTPUT_WIDTH;

   chk_state_e              r_state;
   logic [LOG2_FFT_LEN-1:0] r_smp;
   logic [FW-1:0]           r_acc;
   logic [FW-1:0]           r_frame_sum;
   logic                    r_frame_sum_valid;
   logic [CW-1:0]           r_frm_cnt;
   logic [1:0]              r_bp;
   logic                    r_tready;
   logic                    r_finished;
   logic                    r_pass;
   logic                    r_err_tlast;
   logic                    r_err_index;
   logic                    r_err_timeout;

   logic                    w_run;
   logic                    w_acc;
   logic                    w_last_smp;
   logic [FW-1:0]           w_re_ext;
   logic [FW-1:0]           w_im_ext;
   logic [FW-1:0]           w_acc_nxt;
   logic                    w_err_tlast_nxt;
   logic                    w_err_index_nxt;
   logic [CW-1:0]           w_frm_inc;
   logic [1:0]              w_bp_nxt;
   logic                    w_rdy_run;
   logic                    w_wd_clr;
   logic                    w_wd_tick;
   logic                    w_wd_expire;

   assign w_run      = (r_state == ST_RUN);
   // A beat coinciding with a start pulse is discarded
   assign w_acc      = i_aclken && i_axi4s_data_tvalid && r_tready && w_run && !i_start_test;
   assign w_last_smp = (r_smp == LOG2_FFT_LEN'((1 << LOG2_FFT_LEN) - 1));

   // Components are sign-extended from OUTPUT_WIDTH; padding bits are ignored
   assign w_re_ext  = {{EXT{i_axi4s_data_tdata[OUTPUT_WIDTH-1]}},
                       i_axi4s_data_tdata[OUTPUT_WIDTH-1:0]};
   assign w_im_ext  = {{EXT{i_axi4s_data_tdata[DW+OUTPUT_WIDTH-1]}},
                       i_axi4s_data_tdata[DW +: OUTPUT_WIDTH]};
   assign w_acc_nxt = r_acc + w_re_ext + w_im_ext;

   generate
      if (DW > OUTPUT_WIDTH) begin : g_pad
         logic w_unused_pad;
         assign w_unused_pad = ^{i_axi4s_data_tdata[DW-1:OUTPUT_WIDTH],
                                 i_axi4s_data_tdata[2*DW-1:DW+OUTPUT_WIDTH]};
      end
   endgenerate

   assign w_err_tlast_nxt = r_err_tlast | (i_axi4s_data_tlast != w_last_smp);
   assign w_err_index_nxt = r_err_index | (i_axi4s_data_tuser != r_smp);
   assign w_frm_inc       = (r_frm_cnt == CW'(TEST_FRAME_NUM)) ? r_frm_cnt
                                                               : r_frm_cnt + 1'b1;

   // Free-running backpressure phase; ready drops on phase 3 while running
   assign w_bp_nxt  = r_bp + 2'd1;
   assign w_rdy_run = (BP_EN == 0) || (w_bp_nxt != 2'd3);

   assign w_wd_clr  = i_aclken && (i_start_test || w_acc);
   assign w_wd_tick = i_aclken && w_run && !w_acc;

   ipsxe_fft_chk_watchdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_watchdog (
      .i_aclk   (i_aclk),
      .i_areset (i_areset),
      .i_clr    (w_wd_clr),
      .i_tick   (w_wd_tick),
      .o_expire (w_wd_expire)
   );

   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) begin
         r_state           <= ST_IDLE;
         r_smp             <= '0;
         r_acc             <= '0;
         r_frame_sum       <= '0;
         r_frame_sum_valid <= 1'b0;
         r_frm_cnt         <= '0;
         r_bp              <= 2'd0;
         r_tready          <= 1'b1;
         r_finished        <= 1'b0;
         r_pass            <= 1'b0;
         r_err_tlast       <= 1'b0;
         r_err_index       <= 1'b0;
         r_err_timeout     <= 1'b0;
      end else if (i_aclken) begin
         r_bp              <= w_bp_nxt;
         r_frame_sum_valid <= 1'b0;
         // Ready for the coming cycle; overridden below on state changes
         r_tready          <= w_run ? w_rdy_run : 1'b1;
         if (i_start_test) begin
            r_state       <= ST_RUN;
            r_tready      <= w_rdy_run;
            r_smp         <= '0;
            r_acc         <= '0;
            r_frm_cnt     <= '0;
            r_finished    <= 1'b0;
            r_pass        <= 1'b0;
            r_err_tlast   <= 1'b0;
            r_err_index   <= 1'b0;
            r_err_timeout <= 1'b0;
         end else if (w_run) begin
            if (w_acc) begin
               r_err_tlast <= w_err_tlast_nxt;
               r_err_index <= w_err_index_nxt;
               // Frame end is decided by the sample count, never by tlast
               if (w_last_smp) begin
                  r_frame_sum       <= w_acc_nxt;
                  r_frame_sum_valid <= 1'b1;
                  r_acc             <= '0;
                  r_smp             <= '0;
                  r_frm_cnt         <= w_frm_inc;
                  if (w_frm_inc == CW'(TEST_FRAME_NUM)) begin
                     r_state    <= ST_DONE;
                     r_tready   <= 1'b1;
                     r_finished <= 1'b1;
                     r_pass     <= ~(w_err_tlast_nxt | w_err_index_nxt | r_err_timeout);
                  end
               end else begin
                  r_acc <= w_acc_nxt;
                  r_smp <= r_smp + 1'b1;
               end
            end else if (w_wd_expire) begin
               r_err_timeout <= 1'b1;
               r_state       <= ST_DONE;
               r_tready      <= 1'b1;
               r_finished    <= 1'b1;
               r_pass        <= 1'b0;
            end
         end
      end
   end

   assign o_axi4s_data_tready = r_tready;
   assign o_chk_finished      = r_finished;
   assign o_chk_pass          = r_pass;
   assign o_err_tlast         = r_err_tlast;
   assign o_err_index         = r_err_index;
   assign o_err_timeout       = r_err_timeout;
   assign o_frm_cnt           = r_frm_cnt;
   assign o_frame_sum         = r_frame_sum;
   assign o_frame_sum_valid   = r_frame_sum_valid;

endmodule

// File: tb/tb_ipsxe_fft_result_chk.sv
// ---------------------------------------------------------------------------
// tb_ipsxe_fft_result_chk
// Two checkers: index 0 without backpressure, index 1 with backpressure,
// both with a 100-cycle timeout. A behavioural model (beat counts, a running
// integer sum, an enabled-cycle count) predicts every output on every cycle;
// scenario records and short hand sequences check end-of-test results.
// ---------------------------------------------------------------------------
module tb_ipsxe_fft_result_chk;

   localparam int N   = 16;
   localparam int TFN = 10;
   localparam int TO  = 100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        en   [2];
   logic        st   [2];
   logic        tv   [2];
   logic        last [2];
   logic [47:0] data [2];
   logic [3:0]  user [2];
   logic        rdy  [2];
   logic        fin  [2];
   logic        pass [2];
   logic        etl  [2];
   logic        eidx [2];
   logic        eto  [2];
   logic        fsv  [2];
   logic [3:0]  frm  [2];
   logic [25:0] fsum [2];

   ipsxe_fft_result_chk #(
      .TEST_FRAME_NUM(TFN), .LOG2_FFT_LEN(4), .OUTPUT_WIDTH(21),
      .BP_EN(0), .TIMEOUT_CYCLES(TO)
   ) u_a (
      .i_aclk(clk), .i_areset(rst), .i_aclken(en[0]), .i_start_test(st[0]),
      .i_axi4s_data_tvalid(tv[0]), .i_axi4s_data_tdata(data[0]),
      .i_axi4s_data_tlast(last[0]), .i_axi4s_data_tuser(user[0]),
      .o_axi4s_data_tready(rdy[0]), .o_chk_finished(fin[0]), .o_chk_pass(pass[0]),
      .o_err_tlast(etl[0]), .o_err_index(eidx[0]), .o_err_timeout(eto[0]),
      .o_frm_cnt(frm[0]), .o_frame_sum(fsum[0]), .o_frame_sum_valid(fsv[0])
   );

   ipsxe_fft_result_chk #(
      .TEST_FRAME_NUM(TFN), .LOG2_FFT_LEN(4), .OUTPUT_WIDTH(21),
      .BP_EN(1), .TIMEOUT_CYCLES(TO)
   ) u_b (
      .i_aclk(clk), .i_areset(rst), .i_aclken(en[1]), .i_start_test(st[1]),
      .i_axi4s_data_tvalid(tv[1]), .i_axi4s_data_tdata(data[1]),
      .i_axi4s_data_tlast(last[1]), .i_axi4s_data_tuser(user[1]),
      .o_axi4s_data_tready(rdy[1]), .o_chk_finished(fin[1]), .o_chk_pass(pass[1]),
      .o_err_tlast(etl[1]), .o_err_index(eidx[1]), .o_err_timeout(eto[1]),
      .o_frm_cnt(frm[1]), .o_frame_sum(fsum[1]), .o_frame_sum_valid(fsv[1])
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_on = 1'b0;

   // ---------------- behavioural model ----------------
   // state: 0 idle, 1 run, 2 done
   int          m_st [2];
   int          m_cnt[2];
   int          m_frm[2];
   int          m_idle[2];
   int          m_encyc[2];
   longint      m_tot[2];
   bit          m_etl[2], m_eidx[2], m_eto[2], m_fin[2], m_pass[2], m_fsv[2], m_rdy[2];
   logic [25:0] m_fsum[2];

   task automatic m_reset(input int d);
      m_st[d] = 0; m_cnt[d] = 0; m_frm[d] = 0; m_idle[d] = 0; m_encyc[d] = 0;
      m_tot[d] = 0; m_etl[d] = 0; m_eidx[d] = 0; m_eto[d] = 0; m_fin[d] = 0;
      m_pass[d] = 0; m_fsv[d] = 0; m_rdy[d] = 1; m_fsum[d] = '0;
   endtask

   task automatic m_finish(input int d);
      m_st[d] = 2; m_fin[d] = 1; m_pass[d] = !(m_etl[d] || m_eidx[d] || m_eto[d]);
   endtask

   task automatic m_step(input int d);
      bit acc;
      longint tot;
      if (!en[d]) return;
      acc = (m_st[d] == 1) && tv[d] && m_rdy[d] && !st[d];
      m_fsv[d] = 0;
      if (st[d]) begin
         m_st[d] = 1; m_cnt[d] = 0; m_frm[d] = 0; m_idle[d] = 0; m_tot[d] = 0;
         m_etl[d] = 0; m_eidx[d] = 0; m_eto[d] = 0; m_fin[d] = 0; m_pass[d] = 0;
      end else if (m_st[d] == 1) begin
         if (acc) begin
            m_idle[d] = 0;
            if (int'(user[d]) != m_cnt[d]) m_eidx[d] = 1;
            if (last[d] != (m_cnt[d] == N - 1)) m_etl[d] = 1;
            m_tot[d] += longint'($signed(data[d][23:0])) + longint'($signed(data[d][47:24]));
            if (m_cnt[d] == N - 1) begin
               tot = m_tot[d];
               m_fsum[d] = tot[25:0];
               m_fsv[d] = 1; m_tot[d] = 0; m_cnt[d] = 0;
               if (m_frm[d] < TFN) m_frm[d]++;
               if (m_frm[d] == TFN) m_finish(d);
            end else m_cnt[d]++;
         end else begin
            m_idle[d]++;
            if (m_idle[d] == TO) begin m_eto[d] = 1; m_finish(d); end
         end
      end
      m_encyc[d]++;
      m_rdy[d] = (m_st[d] != 1) || (d == 0) || (m_encyc[d] % 4 != 3);
   endtask

   always @(posedge clk or posedge rst) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) m_reset(d);
         else     m_step(d);
      end
   end

   // Every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (chk_on) begin
         for (int d = 0; d < 2; d++) begin
            logic [35:0] e, o;
            e = {m_rdy[d], m_fin[d], m_pass[d], m_etl[d], m_eidx[d], m_eto[d], m_fsv[d],
                 4'(m_frm[d]), m_fsum[d]};
            o = {rdy[d], fin[d], pass[d], etl[d], eidx[d], eto[d], fsv[d], frm[d], fsum[d]};
            n_cmp++;
            if (o !== e) begin
               n_bad++;
               if (n_bad < 25)
                  $display("FAIL cycle_model dut%0d t=%0t got %h expected %h", d, $time, o, e);
            end
         end
      end
   end

   // ---------------- helpers ----------------
   function automatic logic [47:0] mk(input int re, input int im);
      logic [20:0] r, i;
      r = re[20:0];
      i = im[20:0];
      return {{3{i[20]}}, i, {3{r[20]}}, r};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic start_a();
      st[0] = 1; tv[0] = 0; tick(); st[0] = 0;
   endtask

   task automatic beat_a(input int re, input int im, input int u, input bit l);
      tv[0] = 1; data[0] = mk(re, im); user[0] = u[3:0]; last[0] = l;
      tick();
      tv[0] = 0;
   endtask

   task automatic wait_fin(input int d, input int budget);
      int k;
      k = 0;
      while (!fin[d] && k < budget) begin tick(); k++; end
      check("finish_within_budget", 32'(fin[d]), 32'd1);
   endtask

   // ---------------- scenario table ----------------
   // kind: 0 clean, 1 tlast at smp 7 of frame 3, 2 tuser 5 at smp 4, 3 stall after frame 2
   typedef struct {
      int          kind;
      int          re;
      int          im;
      int          exp_frm;
      bit          exp_pass;
      bit [2:0]    exp_err;   // {timeout, index, tlast}
      logic [25:0] exp_sum;
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{0,  1,  2, 10, 1'b1, 3'b000, 26'd48};
      vecs[1] = '{1,  1,  2, 10, 1'b0, 3'b001, 26'd48};
      vecs[2] = '{2,  1,  2, 10, 1'b0, 3'b010, 26'd48};
      vecs[3] = '{3,  1,  2,  2, 1'b0, 3'b100, 26'd48};
      vecs[4] = '{0, -3,  1, 10, 1'b1, 3'b000, 26'h3FFFFE0};
      vecs[5] = '{0, -(1 << 20), -(1 << 20), 10, 1'b1, 3'b000, 26'h2000000};

      rst = 1;
      for (int d = 0; d < 2; d++) begin
         en[d] = 1; st[d] = 0; tv[d] = 0; last[d] = 0; data[d] = '0; user[d] = '0;
      end
      tick(); tick();
      chk_on = 1;
      tick();
      rst = 0;
      tick();
      check("reset_tready", 32'(rdy[0]), 32'd1);
      check("reset_finished", 32'(fin[0]), 32'd0);
      check("reset_pass", 32'(pass[0]), 32'd0);
      check("reset_frm_cnt", 32'(frm[0]), 32'd0);
      check("reset_frame_sum", 32'(fsum[0]), 32'd0);

      // Table-driven end-of-test results
      for (int v = 0; v < 6; v++) begin
         start_a();
         check("start_clears_finished", 32'(fin[0]), 32'd0);
         for (int f = 0; f < TFN; f++) begin
            if (vecs[v].kind == 3 && f == 2) break;
            for (int s = 0; s < N; s++)
               beat_a(vecs[v].re, vecs[v].im,
                      (vecs[v].kind == 2 && f == 0 && s == 4) ? 5 : s,
                      (s == N - 1) || (vecs[v].kind == 1 && f == 3 && s == 7));
         end
         wait_fin(0, 300);
         check("scn_frm_cnt", 32'(frm[0]), 32'(vecs[v].exp_frm));
         check("scn_pass", 32'(pass[0]), 32'(vecs[v].exp_pass));
         check("scn_errors", 32'({eto[0], eidx[0], etl[0]}), 32'(vecs[v].exp_err));
         check("scn_frame_sum", 32'(fsum[0]), 32'(vecs[v].exp_sum));
      end

      // Start coincident with an accepted beat mid-frame 5
      start_a();
      for (int f = 0; f < 5; f++)
         for (int s = 0; s < N; s++) beat_a(1, 2, s, s == N - 1);
      for (int s = 0; s < 7; s++) beat_a(1, 2, s, 1'b0);
      st[0] = 1;
      beat_a(1, 2, 7, 1'b0);
      st[0] = 0;
      check("restart_frm_cleared", 32'(frm[0]), 32'd0);
      check("restart_not_finished", 32'(fin[0]), 32'd0);
      for (int f = 0; f < TFN; f++)
         for (int s = 0; s < N; s++) beat_a(2, 3, s, s == N - 1);
      wait_fin(0, 50);
      check("restart_frm_cnt", 32'(frm[0]), 32'd10);
      check("restart_pass", 32'(pass[0]), 32'd1);
      check("restart_frame_sum", 32'(fsum[0]), 32'd80);

      // Clock enable low: a bad beat presented must not be seen
      start_a();
      en[0] = 0; tv[0] = 1; user[0] = 4'd5; last[0] = 1; data[0] = mk(7, 7);
      repeat (4) tick();
      en[0] = 1; tv[0] = 0;
      tick();
      check("aclken_low_no_index_err", 32'(eidx[0]), 32'd0);
      check("aclken_low_no_tlast_err", 32'(etl[0]), 32'd0);

      // Asynchronous reset mid-frame
      for (int f = 0; f < 2; f++)
         for (int s = 0; s < N; s++) beat_a(1, 2, s, s == N - 1);
      for (int s = 0; s < 7; s++) beat_a(1, 2, s, 1'b0);
      check("pre_reset_frm", 32'(frm[0]), 32'd2);
      #3 rst = 1;
      #1;
      check("async_reset_frm", 32'(frm[0]), 32'd0);
      check("async_reset_sum", 32'(fsum[0]), 32'd0);
      check("async_reset_tready", 32'(rdy[0]), 32'd1);
      tick(); tick();
      rst = 0;
      tick();

      // Backpressure with a toggling clock enable, tvalid held high
      st[1] = 1; en[1] = 1; tick(); st[1] = 0;
      for (int k = 0; k < 1000 && !m_fin[1]; k++) begin
         en[1] = ~en[1];
         tv[1] = 1; data[1] = mk(1, 2);
         user[1] = 4'(m_cnt[1]); last[1] = (m_cnt[1] == N - 1);
         tick();
      end
      en[1] = 1; tv[1] = 0;
      tick();
      check("bp_finished", 32'(fin[1]), 32'd1);
      check("bp_frm_cnt", 32'(frm[1]), 32'd10);
      check("bp_pass", 32'(pass[1]), 32'd1);
      check("bp_frame_sum", 32'(fsum[1]), 32'd48);

      // Randomized traffic on both checkers, judged by the model every cycle
      for (int d = 0; d < 2; d++) st[d] = 1;
      tick();
      for (int k = 0; k < 3000; k++) begin
         for (int d = 0; d < 2; d++) begin
            int re, im;
            re = int'($urandom_range(0, (1 << 21) - 1)) - (1 << 20);
            im = int'($urandom_range(0, (1 << 21) - 1)) - (1 << 20);
            en[d]   = (d == 0) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
            st[d]   = (m_st[d] == 2) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 399) == 0);
            tv[d]   = ($urandom_range(0, 3) != 0);
            data[d] = mk(re, im);
            user[d] = 4'(m_cnt[d]) ^ (($urandom_range(0, 39) == 0) ? 4'(1 + $urandom_range(0, 14)) : 4'd0);
            last[d] = (m_cnt[d] == N - 1) ^ ($urandom_range(0, 59) == 0);
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
